// File: rtl/sqrt_fixed.sv
// Iterative restoring square root for unsigned fixed-point operands.
// One root bit per cycle, optional round-to-nearest, ready/valid on both sides.
module sqrt_fixed #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_round,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [(WIDTH+FRAC_BITS+1)/2-1:0]    out_root,
  output logic [(WIDTH+FRAC_BITS+1)/2:0]      out_rem,
  output logic                                out_exact
);

  localparam int RW    = (WIDTH + FRAC_BITS + 1) / 2;
  localparam int RAD_W = 2 * RW;
  localparam int CW    = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t            state;
  logic [RAD_W-1:0]  rad;
  logic              rnd;
  logic [RW-1:0]     root;
  logic [RW:0]       rem;
  logic [CW-1:0]     cnt;

  logic [RAD_W-1:0]  rad_in;
  logic [RW+2:0]     rem_sh;
  logic [RW+2:0]     trial;
  logic              fits;
  logic [RW:0]       rem_nx;
  logic [RW-1:0]     root_nx;
  logic [RW-1:0]     root_up;
  logic              go_up;

  assign rad_in  = RAD_W'(in_data) << FRAC_BITS;

  // Partial remainder never exceeds 2*root, so RW+1 bits hold it between steps.
  assign rem_sh  = {rem, rad[RAD_W-1 -: 2]};
  assign trial   = {1'b0, root, 2'b01};
  assign fits    = rem_sh >= trial;
  assign rem_nx  = (RW+1)'(fits ? rem_sh - trial : rem_sh);
  assign root_nx = RW'({root, fits});

  assign root_up = (&root) ? root : root + RW'(1);
  assign go_up   = rnd && (rem > {1'b0, root});

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_root  <= '0;
      out_rem   <= '0;
      out_exact <= 1'b0;
      rad       <= '0;
      rnd       <= 1'b0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            rad      <= rad_in;
            rnd      <= in_round;
            root     <= '0;
            rem      <= '0;
            cnt      <= CW'(RW - 1);
            state    <= CALC;
          end
        end
        CALC: begin
          rad  <= rad << 2;
          rem  <= rem_nx;
          root <= root_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == '0)
            state <= ROUND;
        end
        ROUND: begin
          out_rem   <= rem;
          out_exact <= (rem == '0);
          out_root  <= go_up ? root_up : root;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_fixed.sv
// Scoreboard bench for sqrt_fixed at WIDTH=8, FRAC_BITS=4 (RW=6).
// Expected results come from a brute-force integer sqrt model.
module tb_sqrt_fixed;

  localparam int WIDTH = 8;
  localparam int FRAC  = 4;
  localparam int RW    = (WIDTH + FRAC + 1) / 2;

  typedef struct packed {
    logic [RW-1:0] root;
    logic [RW:0]   rem;
    logic          exact;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic            in_round = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [RW-1:0]   out_root;
  logic [RW:0]     out_rem;
  logic            out_exact;

  int   errors = 0;
  int   checks = 0;
  bit   stall  = 1'b0;
  exp_t sb[$];

  sqrt_fixed #(.WIDTH(WIDTH), .FRAC_BITS(FRAC)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_rem   (out_rem),
    .out_exact (out_exact)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic r);
    exp_t e;
    int big_r;
    int q;
    int rm;
    big_r = int'(a) << FRAC;
    q = 0;
    while ((q + 1) * (q + 1) <= big_r) q++;
    rm = big_r - q * q;
    e.rem   = (RW+1)'(rm);
    e.exact = (rm == 0);
    // Round up when R exceeds (q + 1/2)^2, i.e. 4R > (2q+1)^2.
    if (r && (4 * big_r > (2 * q + 1) * (2 * q + 1)))
      e.root = (q == (1 << RW) - 1) ? RW'(q) : RW'(q + 1);
    else
      e.root = RW'(q);
    return e;
  endfunction

  // Monitor: push on acceptance, pop on result handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (in_valid && in_ready)
        sb.push_back(model(in_data, in_round));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("root", 32'(out_root), 32'(e.root));
          check("rem", 32'(out_rem), 32'(e.rem));
          check("exact", 32'(out_exact), 32'(e.exact));
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic r);
    int n;
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    in_data  = a;
    in_round = r;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 60);
    check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clock);
      #1;
      if (stall)
        out_ready = ($urandom_range(0, 2) != 0);
      n++;
      @(negedge clock);
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t held;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_root", 32'(out_root), 32'd0);
    check("rst_out_rem", 32'(out_rem), 32'd0);
    check("rst_out_exact", 32'(out_exact), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("in_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("in_ready_rise", 32'(in_ready), 32'd1);

    // Scenario 1: 1.0 -> 1.0 exact, latency RW+2
    send(8'h10, 1'b0);
    for (int k = 1; k <= RW + 2; k++) begin
      @(negedge clock);
      if (k < RW + 2) begin
        check("lat_valid_low", 32'(out_valid), 32'd0);
        check("lat_ready_low", 32'(in_ready), 32'd0);
      end else begin
        check("lat_valid_high", 32'(out_valid), 32'd1);
      end
    end
    drain();

    // Scenarios 2 and 3
    send(8'h20, 1'b0); drain();
    send(8'h20, 1'b1); drain();
    send(8'hFF, 1'b1); drain();
    send(8'h90, 1'b0); drain();
    send(8'h00, 1'b1); drain();

    // Scenario 4: backpressure
    out_ready = 1'b0;
    held = model(8'h30, 1'b0);
    send(8'h30, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clock);
        n++;
      end
      check("bp_valid_timeout", 32'(out_valid), 32'd1);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_round = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_root", 32'(out_root), 32'(held.root));
      check("bp_rem", 32'(out_rem), 32'(held.rem));
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_in_ready_rise", 32'(in_ready), 32'd1);
    check("bp_root_held", 32'(out_root), 32'(held.root));
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Scenario 5: reset during the third CALC cycle
    send(8'h40, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    @(negedge clock);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_root", 32'(out_root), 32'd0);
    check("mid_rst_rem", 32'(out_rem), 32'd0);
    check("mid_rst_exact", 32'(out_exact), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    send(8'h40, 1'b0); drain();

    // Scenario 6: full sweep with random rounding and stalls
    stall = 1'b1;
    for (int a = 0; a < 256; a++) begin
      out_ready = ($urandom_range(0, 1) != 0);
      send(8'(a), 1'($urandom_range(0, 1)));
      drain();
    end
    stall = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_fixed.md
Name: sqrt_fixed

Overview:
Parametrised iterative square-root unit for unsigned fixed-point operands with FRAC_BITS fractional bits.
- Computes one root bit per cycle (restoring digit-by-digit); no multipliers.
- Ready/valid handshake on both sides; per-operation round-to-nearest option; exposes remainder and exactness flag.
- Serves as the general-width sqrt for the math library, feeding normalisers and magnitude blocks.

Parameters:
WIDTH, 16, input operand width in bits (unsigned, Q(WIDTH-FRAC_BITS).FRAC_BITS); legal 2..32
FRAC_BITS, 8, fractional bits of input and of result; legal 0..WIDTH
RW (localparam), (WIDTH+FRAC_BITS+1)/2, root width; result is Q(RW-FRAC_BITS).FRAC_BITS

Ports:
clock      input   1        clock, all logic on rising edge
reset      input   1        synchronous, active-high
in_valid   input   1        operand present
in_ready   output  1        block can accept operand
in_data    input   WIDTH    radicand A
in_round   input   1        1 = round result to nearest, 0 = truncate (floor)
out_valid  output  1        result present
out_ready  input   1        downstream accepts result
out_root   output  RW       root
out_rem    output  RW+1     remainder R - q*q, q = truncated root before rounding
out_exact  output  1        1 when out_rem == 0

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. Reset values: in_ready=0, out_valid=0, out_root=0, out_rem=0, out_exact=0, state=IDLE. in_ready rises the first cycle after reset deasserts.
- Math: R = A << FRAC_BITS, zero-extended to 2*RW bits. q = floor(sqrt(R)) (exact integer floor; no precision loss). rem = R - q^2, always <= 2q, fits RW+1 bits.
- States: IDLE, CALC, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch R, in_round; clear root/rem; counter=RW-1; go CALC. in_data and in_round are ignored at all other times.
- CALC (RW cycles): rem' = (rem<<2) | next two MSBs of R; trial = (root<<2)|1. If rem' >= trial: rem = rem' - trial, root = (root<<1)|1. Else rem = rem', root = root<<1. Counter decrements; when it is 0 after the step, go ROUND.
- ROUND (1 cycle): out_rem = rem; out_exact = (rem==0).
  - If latched round==1 and rem > root: out_root = root+1, saturated to all-ones if root is all-ones.
  - Else out_root = root.
  - out_rem/out_exact always reflect the truncated root. Set out_valid=1; go DONE.
- DONE: outputs held stable while out_valid && !out_ready. On out_ready: out_valid=0, go IDLE. in_ready=1 the following cycle.
- Latency: acceptance at cycle 0 -> out_valid high at cycle RW+2. Throughput: one operation per RW+3 cycles when out_ready is held high. No overlap of operations.
- in_ready=0 in CALC, ROUND and DONE; in_valid there is not acknowledged and the upstream must hold its operand.
- out_root, out_rem and out_exact keep their last values after the handshake until the next ROUND.
- A=0 gives root 0, rem 0, exact 1.
- Reset mid-operation: the operation is abandoned, no output is produced, all outputs return to reset values.
- out_ready asserted before out_valid has no effect.

Test Plan:
Scenarios use WIDTH=8, FRAC_BITS=4, RW=6.
1. Reset held 3 cycles, then A=0x10 (1.0), round=0 -> out_root=0x10 (1.0), rem=0, exact=1. out_valid exactly 8 cycles after acceptance; in_ready=0 throughout.
2. A=0x20 (2.0), round=0 -> root=22 (0x16), rem=28, exact=0. Repeat with round=1 -> root=23, rem=28.
3. A=0xFF, round=1 -> truncated root 63, rem=111; rounding saturates, so out_root=63. A=0x90 (9.0) -> root=48 (3.0), exact=1.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> out_valid drops next cycle, in_ready rises next cycle.
5. Reset asserted at the 3rd CALC cycle -> all outputs at reset values, no out_valid. The next operand (A=0x40, result root=32, exact) completes correctly.
6. Random sweep of all 256 A values with random in_round and random out_ready stalls, checked against a golden model. Check q^2 <= R < (q+1)^2, rem = R - q^2, and rounding/saturation.
